fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_mac_unit.sv | 31 +++
 rtl/fir_mac_sched.sv | 128 ++++++++++++
 tb/tb_fir_mac_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the time-multiplexed FIR filter.
package fir_pkg;

    localparam int DEFAULT_TAPS = 4;
    localparam int DEFAULT_DW   = 8;
    localparam int DEFAULT_ACCW = 2 * DEFAULT_DW + $clog2(DEFAULT_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Single shared multiplier feeding an accumulator; clear wins over enable.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW   = DEFAULT_DW,
    parameter int ACCW = DEFAULT_ACCW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] product;

    assign product = a * b;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACCW'(product);
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// FIR filter that walks all taps through one multiplier, one tap per cycle,
// then holds the result until the consumer takes it.
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int TAPS   = DEFAULT_TAPS,
    parameter int DW     = DEFAULT_DW,
    parameter int ACCW   = 2 * DW + $clog2(TAPS),
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    state_t          state;
    state_t          next_state;
    logic [DW-1:0]   coeff      [TAPS];
    logic [DW-1:0]   delay_line [TAPS];
    logic [AW-1:0]   idx;
    logic [ACCW-1:0] acc;
    logic            accept;
    logic            mac_clear;
    logic            mac_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    mac_clear  = 1'b1;
                    next_state = MAC;
                end
            end
            MAC: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Outputs must look idle-and-empty for the whole reset cycle, whatever the state register holds.
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            cfg_err <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coeff[k]      <= DW'(1);
                delay_line[k] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE)) begin
                coeff[cfg_addr] <= cfg_data;
            end
            if (accept) begin
                delay_line[0] <= in_data;
                for (int k = 1; k < TAPS; k++) begin
                    delay_line[k] <= delay_line[k-1];
                end
                idx <= '0;
            end else if (mac_en) begin
                idx <= idx + AW'(1);
            end
        end
    end

    fir_mac_unit #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (coeff[idx]),
        .b      (delay_line[idx]),
        .acc    (acc)
    );

    assign out_data = out_valid ? acc : '0;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: a transaction-level model predicts each
// result and its timing, and a negedge monitor compares what the DUT presents.
module tb_fir_mac_sched;

    localparam int TAPS = fir_pkg::DEFAULT_TAPS;
    localparam int DW   = fir_pkg::DEFAULT_DW;
    localparam int ACCW = 2 * DW + $clog2(TAPS);
    localparam int AW   = $clog2(TAPS);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [DW-1:0]   cfg_data = '0;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [ACCW-1:0] out_data;
    logic            busy;

    always #5 clk = ~clk;

    fir_mac_sched dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    typedef struct {
        int data;
        int due;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   got_q[$];

    // Reference model state: what the filter should hold, at transaction level.
    int   m_coeff [TAPS];
    int   m_hist  [TAPS];
    bit   m_busy = 1'b0;
    int   m_age = 0;
    bit   m_err = 1'b0;

    function automatic void check_output(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    // Model: a sample is taken only when no result is pending; the result is
    // ready TAPS edges later and retires on the first edge with out_ready.
    initial begin
        bit   was_idle;
        int   sum;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_busy = 1'b0;
                m_age  = 0;
                m_err  = 1'b0;
                for (int k = 0; k < TAPS; k++) begin
                    m_coeff[k] = 1;
                    m_hist[k]  = 0;
                end
                sb.delete();
            end else begin
                was_idle = !m_busy;
                m_err = cfg_we && !was_idle;
                if (cfg_we && was_idle) m_coeff[int'(cfg_addr)] = int'(cfg_data);
                if (!was_idle) begin
                    if (m_age >= TAPS && out_ready) m_busy = 1'b0;
                    else if (m_age < TAPS) m_age++;
                end else if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                    m_hist[0] = int'(in_data);
                    sum = 0;
                    for (int k = 0; k < TAPS; k++) sum += m_coeff[k] * m_hist[k];
                    e.data = sum;
                    e.due  = cyc + TAPS;
                    sb.push_back(e);
                    m_busy = 1'b1;
                    m_age  = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard when a new result appears, checks it stays put.
    initial begin
        bit   prev_valid;
        int   held;
        exp_t e;
        prev_valid = 1'b0;
        held = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check_output("rst_in_ready", 32'(in_ready), 0);
                check_output("rst_out_valid", 32'(out_valid), 0);
                check_output("rst_busy", 32'(busy), 0);
                check_output("rst_out_data", 32'(out_data), 0);
                prev_valid = 1'b0;
            end else begin
                check_output("in_ready", 32'(in_ready), m_busy ? 0 : 1);
                check_output("busy", 32'(busy), m_busy ? 1 : 0);
                check_output("cfg_err", 32'(cfg_err), m_err ? 1 : 0);
                check_output("out_valid", 32'(out_valid), (m_busy && m_age >= TAPS) ? 1 : 0);
                if (out_valid === 1'b1) begin
                    if (!prev_valid) begin
                        if (sb.size() == 0) begin
                            check_output("unexpected_out_valid", 1, 0);
                            held = -1;
                        end else begin
                            e = sb.pop_front();
                            held = e.data;
                            check_output("out_data", 32'(out_data), e.data);
                            check_output("latency", cyc, e.due);
                        end
                        got_q.push_back(int'(out_data));
                    end else begin
                        check_output("out_data_stable", 32'(out_data), held);
                    end
                    prev_valid = 1'b1;
                end else begin
                    check_output("out_data_idle", 32'(out_data), 0);
                    prev_valid = 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [DW-1:0] sample, input bit keep, output int acc_cyc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = sample;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                check_output("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                check_output("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = DW'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic check_got(input int pos, input int expected, input string name);
        if (got_q.size() > pos) check_output(name, got_q[pos], expected);
        else check_output({name, "_missing"}, got_q.size(), pos + 1);
    endtask

    initial begin
        int t;
        int acc_c [4];
        int n;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Default unit coefficients: running sums, one sample per TAPS+2 cycles.
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(DW'(i + 1), 1'b1, acc_c[i]);
        in_valid = 1'b0;
        wait_idle();
        for (int i = 1; i < 4; i++) check_output("throughput", acc_c[i] - acc_c[i-1], TAPS + 2);
        check_got(0, 1, "sum1");
        check_got(1, 3, "sum2");
        check_got(2, 6, "sum3");
        check_got(3, 10, "sum4");

        // Programmed coefficients {2,4,6,0}.
        cfg_write(0, 2);
        cfg_write(1, 4);
        cfg_write(2, 6);
        cfg_write(3, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, t);
        wait_idle();
        got_q.delete();
        apply_stimulus(10, 1'b0, t);
        apply_stimulus(0, 1'b0, t);
        wait_idle();
        check_got(0, 20, "coef_first");
        check_got(1, 40, "coef_second");

        // Full-scale operands.
        for (int i = 0; i < 4; i++) cfg_write(i, 255);
        got_q.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(255, 1'b0, t);
        wait_idle();
        check_got(3, 260100, "max_sum");

        // Rejected write during MAC, then write and sample on the same edge.
        for (int i = 0; i < 4; i++) cfg_write(i, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, t);
        wait_idle();
        got_q.delete();
        apply_stimulus(5, 1'b0, t);
        cfg_write(0, 9);
        wait_idle();
        apply_stimulus(3, 1'b0, t);
        wait_idle();
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = 9;
        apply_stimulus(2, 1'b0, t);
        cfg_we = 1'b0;
        wait_idle();
        check_got(0, 5, "pre_reject");
        check_got(1, 8, "coef_kept");
        check_got(2, 26, "same_edge_coef");

        // Consumer stalls for three cycles while a new sample is offered.
        out_ready = 1'b0;
        got_q.delete();
        apply_stimulus(6, 1'b0, t);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            n++;
            if (n > 50) begin
                check_output("hold_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 99;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_idle();
        check_got(0, 64, "stall_result");

        // Reset in the second MAC cycle abandons the sample.
        got_q.delete();
        apply_stimulus(8, 1'b0, t);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("ready_after_reset", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        apply_stimulus(7, 1'b0, t);
        wait_idle();
        check_output("abandoned_count", got_q.size(), 1);
        check_got(0, 7, "post_reset");

        // Randomised traffic, configuration and occasional reset.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = DW'($urandom_range(0, 255));
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = AW'($urandom_range(0, TAPS - 1));
            cfg_data  = DW'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end

        reset     = 1'b0;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_output("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
